// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes engine: substitutes a 128-bit state LANES bytes per cycle,
// forward or inverse S-box selected per block, with valid/ready on both sides.
module sub_bytes_iter #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_chk
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end
  if (!(INV_EN == 0 || INV_EN == 1)) begin : g_inv_chk
    $error("sub_bytes_iter: INV_EN must be 0 or 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            inv_q;
  logic [127:0]    work_q;
  logic [127:0]    work_d;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [3:0]      bidx;
  logic [7:0]      b_in;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] t;
    t = gf_inv(a);
    return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    logic [7:0] t;
    t = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a, input logic use_inv);
    if (INV_EN != 0 && use_inv) return sbox_inv(a);
    return sbox_fwd(a);
  endfunction

  // Substitute only the current chunk; the rest of the working register passes through.
  always_comb begin
    work_d = work_q;
    bidx   = 4'd0;
    b_in   = 8'h00;
    for (int l = 0; l < LANES; l++) begin
      bidx = 4'(int'(cnt_q) * LANES + l);
      b_in = work_q[{bidx, 3'b000} +: 8];
      work_d[{bidx, 3'b000} +: 8] = sbox(b_in, inv_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= in_data;
            inv_q      <= (INV_EN != 0) ? inv : 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          work_q <= work_d;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = work_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter across all LANES values plus a forward-only build.
module tb_sub_bytes_iter;

  localparam int NI = 6;

  logic         clk;
  logic         rst;
  logic         in_valid_s  [NI];
  logic         inv_s       [NI];
  logic         out_ready_s [NI];
  logic [127:0] in_data_s   [NI];
  logic         in_ready_w  [NI];
  logic         out_valid_w [NI];
  logic [127:0] out_data_w  [NI];

  int tests;
  int failed;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  function automatic int lanes_of(input int j);
    case (j)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 8;
      4: return 16;
      default: return 4;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sub_bytes_iter #(.LANES(lanes_of(g)), .INV_EN((g == 5) ? 0 : 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_w[g]),
      .in_data   (in_data_s[g]),
      .inv       (inv_s[g]),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready_s[g]),
      .out_data  (out_data_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

  // Tables from walking the generator 3 (p) and its inverse (q) around GF(2^8)*.
  task automatic build_tables();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      fwd_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic iv);
    logic [127:0] r;
    for (int b = 0; b < 16; b++)
      r[8*b +: 8] = iv ? inv_t[d[8*b +: 8]] : fwd_t[d[8*b +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input int j, input logic [127:0] d, input logic iv);
    @(negedge clk);
    in_data_s[j]  = d;
    inv_s[j]      = iv;
    in_valid_s[j] = 1'b1;
    check("in_ready_idle", 128'(in_ready_w[j]), 128'd1);
    @(posedge clk);
    #1;
    in_valid_s[j] = 1'b0;
  endtask

  // Counts cycles to out_valid while scrambling the inputs that must be ignored.
  task automatic wait_valid(input int j, output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready_w[j] !== 1'b0) busy_ok = 1'b0;
      in_data_s[j]  = {$urandom, $urandom, $urandom, $urandom};
      inv_s[j]      = 1'($urandom);
      in_valid_s[j] = 1'($urandom);
    end while (out_valid_w[j] !== 1'b1 && lat < 64);
    in_valid_s[j] = 1'b0;
    if (lat >= 64) begin
      tests++;
      failed++;
      $display("FAIL timeout: out_valid never rose on instance %0d", j);
    end
  endtask

  task automatic handshake(input int j);
    @(negedge clk);
    out_ready_s[j] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[j] = 1'b0;
    check("out_valid_fall", 128'(out_valid_w[j]), 128'd0);
    check("in_ready_rise", 128'(in_ready_w[j]), 128'd1);
  endtask

  task automatic run_block(input int j, input logic [127:0] d, input logic iv,
                           input logic [127:0] exp);
    int   lat;
    logic busy_ok;
    accept(j, d, iv);
    wait_valid(j, lat, busy_ok);
    check("latency", 128'(lat), 128'(16 / lanes_of(j)));
    check("in_ready_busy", 128'(busy_ok), 128'd1);
    check("out_data", out_data_w[j], exp);
    handshake(j);
  endtask

  typedef struct {
    int           inst;
    logic [127:0] din;
    logic         iv;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] PT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] S0 = {16{8'h63}};

  vec_t vecs [12];

  initial begin
    int           lat;
    int           j;
    logic         busy_ok;
    logic         iv;
    logic [127:0] d;
    logic [127:0] exp;

    tests  = 0;
    failed = 0;
    build_tables();
    vecs[0]  = '{2, PT, 1'b0, CT};
    vecs[1]  = '{0, CT, 1'b1, PT};
    vecs[2]  = '{0, 128'h0, 1'b0, S0};
    vecs[3]  = '{0, PT, 1'b0, CT};
    vecs[4]  = '{1, PT, 1'b0, CT};
    vecs[5]  = '{3, PT, 1'b0, CT};
    vecs[6]  = '{4, PT, 1'b0, CT};
    vecs[7]  = '{5, 128'h0, 1'b1, S0};
    vecs[8]  = '{5, PT, 1'b1, CT};
    vecs[9]  = '{4, CT, 1'b1, PT};
    vecs[10] = '{1, CT, 1'b1, PT};
    vecs[11] = '{3, S0, 1'b1, 128'h0};

    for (int k = 0; k < NI; k++) begin
      in_valid_s[k]  = 1'b0;
      inv_s[k]       = 1'b0;
      out_ready_s[k] = 1'b0;
      in_data_s[k]   = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      check("rst_in_ready", 128'(in_ready_w[k]), 128'd1);
      check("rst_out_valid", 128'(out_valid_w[k]), 128'd0);
      check("rst_out_data", out_data_w[k], 128'h0);
    end

    for (int k = 0; k < 12; k++)
      run_block(vecs[k].inst, vecs[k].din, vecs[k].iv, vecs[k].exp);

    // Backpressure: DONE must hold through 10 stalled cycles of input noise.
    exp = ref_sub(PT, 1'b0);
    accept(2, PT, 1'b0);
    wait_valid(2, lat, busy_ok);
    check("bp_latency", 128'(lat), 128'd4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_out_data", out_data_w[2], exp);
      check("bp_out_valid", 128'(out_valid_w[2]), 128'd1);
      check("bp_in_ready", 128'(in_ready_w[2]), 128'd0);
      in_data_s[2]  = {$urandom, $urandom, $urandom, $urandom};
      inv_s[2]      = 1'($urandom);
      in_valid_s[2] = 1'($urandom);
    end
    in_valid_s[2] = 1'b0;
    handshake(2);
    @(posedge clk);
    #1;
    check("bp_no_reaccept", 128'(in_ready_w[2]), 128'd1);

    // Reset after two chunks of a LANES=1 block.
    accept(0, PT, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 128'(out_valid_w[0]), 128'd0);
    check("mid_rst_out_data", out_data_w[0], 128'h0);
    check("mid_rst_in_ready", 128'(in_ready_w[0]), 128'd1);
    run_block(0, CT, 1'b1, PT);

    for (int r = 0; r < 30; r++) begin
      j  = int'($urandom_range(0, NI - 1));
      d  = {$urandom, $urandom, $urandom, $urandom};
      iv = 1'($urandom);
      run_block(j, d, iv, ref_sub(d, iv & (j != 5)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
